perf_event_monitor: RTL and testbench
=====================================

// Module: perf_event_monitor
// PURPOSE
//  Synthesizable successor to the bench-side stall/flush tallies. Counts free-running
//  cycles plus NUM_EVENTS qualified pipeline events (stall, flush, retire, ...).
//  Supports a run window, atomic snapshot, registered readout and overflow flags.
//  Sits beside CPU; event_i bits are driven by hazard/flush logic, already qualified.
// PARAMETERS
//  NUM_EVENTS   4    number of event channels (1..15)
//  CNT_WIDTH    32   width of every counter (8..64)
//  STOP_CYCLES  64   cycle count at which RUN ends; 0 = run until clear
//  SATURATE     1    1: counters hold at all-ones on overflow; 0: wrap to 0
// PORTS
//  clk_i        in   1                       clock, rising edge
//  rst_i        in   1                       synchronous reset, active-low
//  start_i      in   1                       run enable (level)
//  clear_i      in   1                       zero live counters/flags, return to IDLE
//  event_i      in   NUM_EVENTS              per-cycle event strobes
//  snap_i       in   1                       copy live counters into shadow bank
//  rd_sel_i     in   SELW=$clog2(NUM_EVENTS+1)  0 = cycle, k = event k-1
//  rd_data_o    out  CNT_WIDTH               shadow[rd_sel_i], registered
//  ovf_o        out  NUM_EVENTS+1            sticky overflow; bit0 = cycle counter
//  running_o    out  1                       state == RUN
//  done_o       out  1                       state == DONE
// BEHAVIOUR
//  Reset (rst_i==0 at edge): state IDLE; all live, shadow counters 0; ovf_o 0;
//   rd_data_o 0; running_o 0; done_o 0. Reset overrides every other input.
//  States: IDLE, RUN, PAUSE, DONE.
//   IDLE : start_i=1 -> RUN. No counting.
//   RUN  : each cycle cycle_cnt+=1; event k cnt+=1 iff event_i[k]. start_i=0 -> PAUSE
//          (the cycle start_i is seen low does not count). cycle_cnt reaching STOP_CYCLES
//          (value after this edge == STOP_CYCLES, STOP_CYCLES!=0) -> DONE.
//   PAUSE: counters frozen; start_i=1 -> RUN.
//   DONE : counters frozen; start_i ignored; only clear_i or reset leaves.
//  Counting on an edge happens iff state==RUN and start_i==1 before that edge.
//  clear_i (any state): live counters 0, ovf_o 0, state -> IDLE; beats increments.
//   Shadow bank NOT cleared by clear_i.
//  Overflow: incrementing an all-ones counter sets its ovf bit (sticky).
//   SATURATE=1: value stays all-ones. SATURATE=0: value becomes 0.
//  Snapshot: snap_i at edge N loads shadow with live values as they were BEFORE edge N
//   (excludes edge N increment). snap_i + clear_i same edge: shadow gets pre-clear values.
//  Readout: rd_data_o at edge N+1 = shadow[rd_sel_i sampled at edge N]; 1-cycle latency.
//   rd_sel_i > NUM_EVENTS -> rd_data_o = 0. Same-edge snap + read returns old shadow.
//  Width rule: all counters CNT_WIDTH unsigned; STOP_CYCLES compared zero-extended;
//   STOP_CYCLES >= 2^CNT_WIDTH is a parameter error (elaboration $error).
// TESTING
//  1 reset: hold rst_i=0 2 cycles with start_i=1, events=all-ones -> all outputs 0, IDLE.
//  2 window: start_i=1, event_i[0]=1 every cycle, event_i[1] every 2nd, STOP_CYCLES=64 ->
//    done_o after 64 counting edges; snap, read sel 0/1/2 -> 64, 64, 32; further events ignored.
//  3 pause: RUN 10 cycles, start_i=0 for 5, start_i=1 for 10 -> cycle counter 20, PAUSE ->
//    running_o=0 during gap.
//  4 overflow: CNT_WIDTH=8, STOP_CYCLES=0, event_i[0]=1 for 300 cycles -> SATURATE=1: 255,
//    ovf_o[1]=1; SATURATE=0: 300 mod 256 = 44, ovf_o[1]=1; ovf_o[0] likewise for cycles.
//  5 snap/clear collision: live cycle=37, snap_i=clear_i=1 same edge -> shadow[0]=37,
//    live 0, IDLE, ovf_o 0; read sel 0 next cycle -> 37; sel 7 (N=4) -> 0.
//  6 reset mid-RUN: rst_i=0 one edge at cycle 20 -> counters, shadow, flags 0, IDLE; restart
//    counts from 0.

Source files
------------

// File: rtl/perf_event_monitor.sv
// Purpose : cycle counter plus NUM_EVENTS qualified event counters with a run window,
//           atomic snapshot into a shadow bank and sticky per-counter overflow flags.
// Latency : counting takes effect on the edge that samples the event; readout of
//           shadow[rd_sel_i] appears on rd_data_o one edge after rd_sel_i is sampled.
// Backpressure: none; event strobes are consumed every cycle and cannot be stalled.
// Ports   : clk_i/rst_i (sync, active-low) clock and reset; start_i run level;
//           clear_i zero live state; event_i per-cycle strobes; snap_i copy live to
//           shadow; rd_sel_i/rd_data_o registered shadow readout; ovf_o sticky
//           overflow (bit0 = cycle counter); running_o/done_o window state.
module perf_event_monitor #(
  parameter int              NUM_EVENTS  = 4,
  parameter int              CNT_WIDTH   = 32,
  parameter longint unsigned STOP_CYCLES = 64,
  parameter bit              SATURATE    = 1'b1,
  localparam int             SELW        = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  snap_i,
  input  logic [SELW-1:0]       rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic                  running_o,
  output logic                  done_o
);

  // Elaboration-time parameter checks.
  if (NUM_EVENTS < 1 || NUM_EVENTS > 15) begin : g_bad_num_events
    $error("perf_event_monitor: NUM_EVENTS must be in 1..15");
  end
  if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cnt_width
    $error("perf_event_monitor: CNT_WIDTH must be in 8..64");
  end
  if (CNT_WIDTH < 64 && STOP_CYCLES >= (64'd1 << CNT_WIDTH)) begin : g_bad_stop
    $error("perf_event_monitor: STOP_CYCLES does not fit in CNT_WIDTH");
  end

  localparam int                   NCNT     = NUM_EVENTS + 1;
  localparam bit                   STOP_EN  = (STOP_CYCLES != 64'd0);
  localparam logic [CNT_WIDTH-1:0] STOP_VAL = CNT_WIDTH'(STOP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt      [NCNT];
  logic [CNT_WIDTH-1:0]  cnt_nxt  [NCNT];
  logic [CNT_WIDTH-1:0]  shadow   [NCNT];
  logic [NUM_EVENTS:0]   ovf, ovf_nxt;
  logic [NUM_EVENTS:0]   inc;
  logic                  count_en;
  logic [CNT_WIDTH-1:0]  rd_mux;

  // Slot 0 is the free-running cycle counter; slot k is event k-1.
  assign inc      = {event_i, 1'b1};
  // The cycle in which start_i drops does not count.
  assign count_en = (state == RUN) && start_i;

  always_comb begin
    ovf_nxt = ovf;
    for (int k = 0; k < NCNT; k++) begin
      cnt_nxt[k] = cnt[k];
      if (count_en && inc[k]) begin
        if (&cnt[k]) begin
          ovf_nxt[k] = 1'b1;
          cnt_nxt[k] = SATURATE ? cnt[k] : '0;
        end else begin
          cnt_nxt[k] = cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Next-state logic. The stop test looks at the post-edge cycle value so DONE is
  // entered on the same edge that brings the counter to STOP_CYCLES.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = RUN;
      RUN: begin
        if (!start_i)                                 state_nxt = PAUSE;
        else if (STOP_EN && (cnt_nxt[0] == STOP_VAL)) state_nxt = DONE;
      end
      PAUSE: if (start_i) state_nxt = RUN;
      DONE:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end

  // Out-of-range selects fall through every compare and read back zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel_i == SELW'(k)) rd_mux = shadow[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      ovf       <= '0;
      rd_data_o <= '0;
      for (int k = 0; k < NCNT; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      // rd_mux reads the pre-edge shadow, so a same-edge snap is not visible yet.
      rd_data_o <= rd_mux;
      // Snapshot captures pre-edge live values, hence also pre-clear values.
      if (snap_i) begin
        for (int k = 0; k < NCNT; k++) shadow[k] <= cnt[k];
      end
      if (clear_i) begin
        ovf <= '0;
        for (int k = 0; k < NCNT; k++) cnt[k] <= '0;
      end else begin
        ovf <= ovf_nxt;
        for (int k = 0; k < NCNT; k++) cnt[k] <= cnt_nxt[k];
      end
    end
  end

  assign ovf_o     = ovf;
  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: three instances share stimulus (default, 8-bit
// saturating, 8-bit wrapping). Expected values are queued by the stimulus and
// compared by a separate monitor when read data or status probes become valid.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, clear, snap;
  logic [3:0] event_v;
  logic [2:0] rd_sel;

  logic [31:0] rd0;
  logic [7:0]  rd1, rd2;
  logic [4:0]  ovf0, ovf1, ovf2;
  logic        run0, run1, run2, done0, done1, done2;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .STOP_CYCLES(64), .SATURATE(1'b1)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(event_v),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd0), .ovf_o(ovf0),
    .running_o(run0), .done_o(done0));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(8), .STOP_CYCLES(0), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(event_v),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd1), .ovf_o(ovf1),
    .running_o(run1), .done_o(done1));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(8), .STOP_CYCLES(0), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(event_v),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd2), .ovf_o(ovf2),
    .running_o(run2), .done_o(done2));

  // kind: 0 ovf_o, 1 running_o, 2 done_o, 3 rd_data_o (direct)
  typedef struct {
    int          dut;
    int          kind;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t rd_q[$];
  chk_t st_q[$];
  chk_t mon_c;
  int   checks = 0;
  int   errors = 0;
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  logic st_req = 1'b0;

  function automatic logic [63:0] get_val(int d, int kind);
    logic [63:0] v;
    v = '0;
    case (kind)
      0: v = (d == 0) ? 64'(ovf0) : (d == 1) ? 64'(ovf1) : 64'(ovf2);
      1: v = (d == 0) ? 64'(run0) : (d == 1) ? 64'(run1) : 64'(run2);
      2: v = (d == 0) ? 64'(done0) : (d == 1) ? 64'(done1) : 64'(done2);
      default: v = (d == 0) ? 64'(rd0) : (d == 1) ? 64'(rd1) : 64'(rd2);
    endcase
    return v;
  endfunction

  task automatic compare(input chk_t c);
    logic [63:0] act;
    act = get_val(c.dut, c.kind);
    checks++;
    if (act !== c.exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0d, expected %0d", c.name, c.dut, act, c.exp);
    end
  endtask

  // Read data is valid one edge after the select is sampled.
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got read data with no expected entry, expected queued entry");
      end else begin
        mon_c = rd_q.pop_front();
        mon_c.kind = 3;
        compare(mon_c);
      end
    end
    if (st_req) begin
      while (st_q.size() > 0) begin
        mon_c = st_q.pop_front();
        compare(mon_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int d, input int sel, input logic [63:0] e, input string n);
    rd_q.push_back('{d, 3, e, n});
    rd_sel = 3'(sel);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic status(input int d, input logic [63:0] o, input logic [63:0] r,
                        input logic [63:0] dn, input string n);
    st_q.push_back('{d, 0, o,  {n, "_ovf"}});
    st_q.push_back('{d, 1, r,  {n, "_running"}});
    st_q.push_back('{d, 2, dn, {n, "_done"}});
  endtask

  task automatic st_go();
    st_req = 1'b1;
    @(negedge clk);
    #1;
    st_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: reset dominates start, events and snap
    rst = 1'b0; start = 1'b1; clear = 1'b0; snap = 1'b1; event_v = 4'hF; rd_sel = '0;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      status(d, 0, 0, 0, "reset");
      st_q.push_back('{d, 3, 64'd0, "reset_rd"});
    end
    st_go();
    rst = 1'b1; start = 1'b0; snap = 1'b0; event_v = 4'h0;
    tick();

    // 2: run window ends after 64 counting edges
    start = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        status(0, 0, 1, 0, "win_pre");
        st_go();
      end
      event_v = {2'b00, 1'(i % 2 == 0), 1'b1};
      tick();
    end
    status(0, 0, 0, 1, "win_end");
    st_go();
    event_v = 4'hF;
    repeat (5) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0; event_v = 4'h0;
    rd(0, 0, 64, "win_cyc");
    rd(0, 1, 64, "win_e0");
    rd(0, 2, 32, "win_e1");
    rd(0, 3, 0,  "win_e2_frozen");
    start = 1'b0;
    do_clear();
    status(0, 0, 0, 0, "win_clr");
    st_go();

    // 3: pause freezes counting
    event_v = 4'b0100; start = 1'b1;
    repeat (11) tick();
    start = 1'b0;
    repeat (5) tick();
    status(0, 0, 0, 0, "pause_gap");
    st_go();
    start = 1'b1;
    repeat (11) tick();
    status(0, 0, 1, 0, "pause_resumed");
    st_go();
    start = 1'b0;
    tick();
    snap = 1'b1;
    tick();
    snap = 1'b0; event_v = 4'h0;
    rd(0, 0, 20, "pause_cyc");
    rd(0, 3, 20, "pause_e2");
    rd(0, 1, 0,  "pause_e0");
    do_clear();

    // 4: 8-bit overflow, saturating vs wrapping
    event_v = 4'b0001; start = 1'b1;
    tick();
    repeat (255) tick();
    status(1, 0, 1, 0, "sat_255");
    status(2, 0, 1, 0, "wrap_255");
    st_go();
    snap = 1'b1;
    tick();                       // 256th counting edge; shadow takes pre-edge 255
    snap = 1'b0;
    status(1, 5'b00011, 1, 0, "sat_256");
    status(2, 5'b00011, 1, 0, "wrap_256");
    st_go();
    rd(1, 0, 255, "sat_snap_pre");
    rd(2, 0, 255, "wrap_snap_pre");
    repeat (42) tick();           // 258 + 42 = 300 counting edges
    start = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; event_v = 4'h0;
    rd(1, 0, 255, "sat_cyc");
    rd(1, 1, 255, "sat_e0");
    rd(1, 2, 0,   "sat_e1");
    rd(2, 0, 44,  "wrap_cyc");
    rd(2, 1, 44,  "wrap_e0");
    rd(0, 0, 64,  "main_stop_cyc");
    rd(0, 1, 64,  "main_stop_e0");
    status(1, 5'b00011, 0, 0, "sat_end");
    status(2, 5'b00011, 0, 0, "wrap_end");
    status(0, 0, 0, 1, "main_end");
    st_go();
    do_clear();
    status(1, 0, 0, 0, "sat_clr");
    status(2, 0, 0, 0, "wrap_clr");
    st_go();

    // 5: snapshot and clear on the same edge
    start = 1'b1;
    tick();
    repeat (37) tick();
    snap = 1'b1; clear = 1'b1;
    tick();
    snap = 1'b0; clear = 1'b0; start = 1'b0;
    status(0, 0, 0, 0, "coll");
    st_go();
    rd(0, 0, 37, "coll_shadow");
    rd(0, 7, 0,  "coll_sel7");
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd(0, 0, 0, "coll_live");

    // 6: reset in the middle of a run
    event_v = 4'b0001; start = 1'b1;
    tick();
    repeat (10) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    status(0, 0, 0, 0, "rst_mid");
    st_q.push_back('{0, 3, 64'd0, "rst_mid_rd"});
    st_go();
    rd(0, 0, 0, "rst_shadow");
    repeat (5) tick();
    start = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; event_v = 4'h0;
    rd(0, 0, 5, "restart_cyc");
    rd(0, 1, 5, "restart_e0");

    repeat (3) tick();
    checks++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d pending, expected 0/0", rd_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
